// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller for the five-stage RISC-V core.
//                Detects load-use and branch-operand dependencies, sequences
//                multi-cycle data-memory waits, and drives the PC / IF/ID
//                enables, IF/ID flush, decode bubble select and a global
//                pipeline freeze. Keeps saturating stall/flush counters and a
//                sticky memory-timeout flag.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // instruction in ID
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic             Branch_i,
    input  logic             Jump_i,
    input  logic             Ret_i,
    input  logic [1:0]       PCsrc_i,
    // instruction in EX
    input  logic             RegWriteEX_i,
    input  logic             MemReadEX_i,
    input  logic [4:0]       rdEX_i,
    // instruction in MEM
    input  logic             MemReadMEM_i,
    input  logic [4:0]       rdMEM_i,
    // data memory
    input  logic             memBusy_i,
    // pipeline control
    output logic             PCen_o,
    output logic             IFIDen_o,
    output logic             IFIDflush_o,
    output logic             controlZeroSel_o,
    output logic             stallAll_o,
    // status
    output logic [CNT_W-1:0] stallCnt_o,
    output logic [CNT_W-1:0] flushCnt_o,
    output logic             timeout_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = c_WAIT_W'(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);
    localparam int                c_NUM_PERF  = 2;

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------------
    logic                w_ex_rs1;
    logic                w_ex_rs2;
    logic                w_mem_rs1;
    logic                w_mem_rs2;
    logic                w_ex_dep_rs1;
    logic                w_ex_dep_rs2;
    logic                w_mem_dep_rs1;
    logic                w_mem_dep_rs2;
    logic                w_load_use;
    logic                w_br_dep;
    logic                w_data_stall;
    logic                w_redirect;

    logic                w_pc_en;
    logic                w_ifid_en;
    logic                w_ifid_flush;
    logic                w_ctrl_zero;
    logic                w_stall_all;

    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_timeout;

    logic [CNT_W-1:0]    r_perf_cnt [c_NUM_PERF];
    logic [c_NUM_PERF-1:0] w_perf_evt;

    // A jump's target does not come from a forwarded register operand, so it
    // never creates a dependency; the flag is kept on the port list only to
    // keep the decode interface uniform.
    logic                w_unused_jump;
    assign w_unused_jump = Jump_i;

    // ------------------------------------------------------------------------
    // Register-match terms; x0 is hardwired to zero and never a hazard
    // ------------------------------------------------------------------------
    assign w_ex_rs1  = (rdEX_i  != 5'd0) && (rdEX_i  == rs1_i);
    assign w_ex_rs2  = (rdEX_i  != 5'd0) && (rdEX_i  == rs2_i);
    assign w_mem_rs1 = (rdMEM_i != 5'd0) && (rdMEM_i == rs1_i);
    assign w_mem_rs2 = (rdMEM_i != 5'd0) && (rdMEM_i == rs2_i);

    // Branch comparison happens in ID, so it needs the EX result written back
    // (any register write) or a MEM-stage load that has not yet returned data.
    assign w_ex_dep_rs1  = RegWriteEX_i && w_ex_rs1;
    assign w_ex_dep_rs2  = RegWriteEX_i && w_ex_rs2;
    assign w_mem_dep_rs1 = MemReadMEM_i && w_mem_rs1;
    assign w_mem_dep_rs2 = MemReadMEM_i && w_mem_rs2;

    assign w_load_use = MemReadEX_i && (w_ex_rs1 || w_ex_rs2);

    // JALR reads only rs1; conditional branches read both sources.
    assign w_br_dep = (Branch_i && (w_ex_dep_rs1 || w_ex_dep_rs2 ||
                                    w_mem_dep_rs1 || w_mem_dep_rs2)) ||
                      (Ret_i    && (w_ex_dep_rs1 || w_mem_dep_rs1));

    assign w_data_stall = w_load_use || w_br_dep;

    // A redirect computed from stale operands is not trusted until the stall
    // has resolved.
    assign w_redirect = (PCsrc_i != 2'b00) && !w_data_stall;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; the release cycle of a wait is handled like RUN
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (memBusy_i) begin
                    w_state_nxt = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (!memBusy_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Pipeline control outputs: reset > memory wait > data stall > redirect.
    // A busy memory freezes the pipe in both states, and a MEM_WAIT cycle with
    // the memory released falls through to the normal hazard evaluation.
    always_comb begin
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_ifid_flush = 1'b0;
        w_ctrl_zero  = 1'b0;
        w_stall_all  = 1'b0;
        if (rst_i) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_ifid_flush = 1'b1;
            w_ctrl_zero  = 1'b1;
        end else if (memBusy_i) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_stall_all  = 1'b1;
        end else if (w_data_stall) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_ctrl_zero  = 1'b1;
        end else if (w_redirect) begin
            w_ifid_flush = 1'b1;
        end
    end

    assign PCen_o           = w_pc_en;
    assign IFIDen_o         = w_ifid_en;
    assign IFIDflush_o      = w_ifid_flush;
    assign controlZeroSel_o = w_ctrl_zero;
    assign stallAll_o       = w_stall_all;

    // Wait-cycle counter: counts busy cycles spent in MEM_WAIT, holds at
    // TIMEOUT so it cannot wrap while a stuck memory keeps the wait going
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_wait_cnt <= '0;
        end else if (memBusy_i && (r_wait_cnt != c_WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
        end
    end

    // Sticky timeout: set on the edge where the wait counter reaches TIMEOUT
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else if ((r_state == ST_MEM_WAIT) && memBusy_i &&
                     (r_wait_cnt == c_WAIT_LAST)) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;

    // ------------------------------------------------------------------------
    // Saturating performance counters: [0] stall cycles, [1] flush cycles.
    // Reset cycles are excluded since the counters are cleared then anyway.
    // ------------------------------------------------------------------------
    assign w_perf_evt[0] = !w_pc_en;
    assign w_perf_evt[1] = w_ifid_flush;

    generate
        for (genvar gi = 0; gi < c_NUM_PERF; gi++) begin : g_perf_cnt
            // Count the event, stopping at all-ones
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_perf_cnt[gi] <= '0;
                end else if (w_perf_evt[gi] && (r_perf_cnt[gi] != '1)) begin
                    r_perf_cnt[gi] <= r_perf_cnt[gi] + c_CNT_ONE;
                end
            end
        end
    endgenerate

    assign stallCnt_o = r_perf_cnt[0];
    assign flushCnt_o = r_perf_cnt[1];

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It watches the decode-stage instruction, the EX/MEM destination registers and the data-memory busy flag. From these it drives the PC enable, the IF/ID enable and flush, the decode control-zero select, and a global pipeline freeze. A small FSM handles multi-cycle memory waits, and the block keeps saturating stall/flush performance counters plus a sticky memory-timeout flag.

## Interface
Parameters:
- TIMEOUT, 1024: memory-wait cycles after which timeout_o sets (≥2)
- CNT_W, 32: width of the performance counters

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- rs1_i, rs2_i  in  5  source registers of the instruction in ID
- Branch_i, Jump_i, Ret_i  in  1  ID decode flags; Ret = JALR, reads rs1 only
- PCsrc_i  in  2  PC select computed in ID; nonzero = redirect
- RegWriteEX_i, MemReadEX_i  in  1  control bits of the instruction in EX
- rdEX_i  in  5  destination of the instruction in EX
- MemReadMEM_i  in  1  instruction in MEM is a load
- rdMEM_i  in  5  destination of the instruction in MEM
- memBusy_i  in  1  data memory cannot complete this cycle
- PCen_o  out  1  PC register update enable
- IFIDen_o  out  1  IF/ID register update enable
- IFIDflush_o  out  1  IF/ID loads a NOP (all-zero instruction)
- controlZeroSel_o  out  1  zero the ID→EX control bits (bubble)
- stallAll_o  out  1  freeze the ID/EX, EX/MEM and MEM/WB registers
- stallCnt_o  out  CNT_W  cycles with PCen_o=0, saturating
- flushCnt_o  out  CNT_W  cycles with IFIDflush_o=1, saturating
- timeout_o  out  1  sticky: a memory wait exceeded TIMEOUT

## Operation
- Hazard terms are combinational. A register match requires a nonzero destination.
  - loadUse = MemReadEX_i and rdEX_i matches rs1_i or rs2_i.
  - brDep = (Branch_i and (rdEX_i or rdMEM_i matches rs1/rs2)) or (Ret_i and a match on rs1 only). The EX-side match qualifies on RegWriteEX_i; the MEM-side match qualifies on MemReadMEM_i. Jump_i alone never depends.
  - dataStall = loadUse or brDep.
  - redirect = (PCsrc_i != 0) and not dataStall.
- FSM states: RUN and MEM_WAIT.
  - RUN→MEM_WAIT when memBusy_i=1.
  - MEM_WAIT→RUN on the first cycle with memBusy_i=0. That cycle is evaluated as RUN.
- Output priority: memory wait > dataStall > redirect.
  - MEM_WAIT, or RUN with memBusy_i=1: stallAll=1, PCen=0, IFIDen=0, flush=0, controlZeroSel=0.
  - RUN with dataStall: PCen=0, IFIDen=0, controlZeroSel=1, flush=0, stallAll=0.
  - RUN with redirect: PCen=1, IFIDen=1, flush=1, controlZeroSel=0.
  - Otherwise: PCen=1, IFIDen=1, all others 0.
- Wait counter (internal, ≥ clog2(TIMEOUT+1) bits):
  - Clears to 0 in RUN.
  - Increments each MEM_WAIT cycle in which memBusy_i=1.
  - When it reaches TIMEOUT, timeout_o sets and stays set until rst_i.
  - Waiting continues after timeout; the FSM is not forced out.
- stallCnt_o and flushCnt_o each increment by 1 on every cycle their condition holds. They stop at 2^CNT_W−1 and never wrap.

## Timing
- All hazard outputs are combinational from the current state and inputs, with zero-cycle latency. The counters, timeout_o and the state register are updated at the clock edge.
- Reset (rst_i=1 sampled at an edge):
  - state=RUN; wait counter, stallCnt_o, flushCnt_o and timeout_o = 0.
  - While rst_i is high, outputs are forced: PCen=0, IFIDen=0, flush=1, controlZeroSel=1, stallAll=0.
  - Counters do not count reset cycles.
- Reset asserted during MEM_WAIT returns the block to RUN on the next edge, regardless of memBusy_i.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load has moved to MEM, so loadUse clears and only brDep can still hold.
- A branch that depends on a load stalls 2 cycles: first on the EX match, then on the MEM match.
- memBusy_i asserted in the same cycle as dataStall or redirect: the memory wait wins. That cycle produces no flush and no bubble, and the hazard is re-evaluated after the wait ends.
- Same-edge timeout and memBusy_i drop: timeout_o still sets.

## Test plan
- Reset: hold rst_i for 3 cycles, then release with all inputs 0 → during reset PCen=0, flush=1; after release PCen=1, and stallCnt_o=0, flushCnt_o=0, timeout_o=0.
- Load-use: MemReadEX_i=1, rdEX_i=5, rs2_i=5 for one cycle → PCen=0, IFIDen=0, controlZeroSel=1 for exactly 1 cycle; stallCnt_o=1. Repeating with rdEX_i=0 → no stall.
- Dependent branch: Branch_i=1, rs1_i=7, RegWriteEX_i=1, MemReadEX_i=1, rdEX_i=7 in cycle 1; MemReadMEM_i=1, rdMEM_i=7 in cycle 2; PCsrc_i=1 throughout → 2 stall cycles, then 1 flush cycle; stallCnt_o=2, flushCnt_o=1.
- Memory wait: memBusy_i=1 for 4 cycles with PCsrc_i=1 held → stallAll=1 and no flush for 4 cycles, then flush=1 on the release cycle.
- Timeout: TIMEOUT=8, memBusy_i held for 12 cycles → timeout_o rises on the edge after the 8th MEM_WAIT busy cycle and stays 1 after memBusy_i drops, until rst_i.
- Saturation: CNT_W=4, dataStall held for 20 cycles → stallCnt_o stops at 15.
